// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//
// Initiator side of the iterative divider interface. Takes RV32M
// DIV/DIVU/REM/REMU requests from the execute stage, launches the divider
// with a one-cycle start pulse, waits for its ready and returns quotient or
// remainder together with the divide-by-zero / signed-overflow flags.
// Only one divide is ever in flight; a flush while the divider is busy
// drains the running divide without producing a response.
//
// Optional feature (macro DIV_CACHE_EN): a single-entry result cache keyed
// on {a, b, signedness}. A matching request answers one cycle after accept
// without touching the divider. Undefined by default.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_op                   bit0 = unsigned, bit1 = remainder
//   req_a, req_b             dividend, divisor
//   flush                    discard the in-flight op
//   resp_valid               one-cycle result pulse
//   resp_data                quotient or remainder
//   resp_dbz, resp_ovf       status flags, valid with resp_valid
//   dv_en                    divider start pulse
//   dv_a, dv_b, dv_is_signed divider operands and mode
//   dv_ready, dv_q, dv_r,
//   dv_div_by_zero,
//   dv_overflow              divider results
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_dbz,
    output logic             resp_ovf,
    output logic             dv_en,
    output logic [WIDTH-1:0] dv_a,
    output logic [WIDTH-1:0] dv_b,
    output logic             dv_is_signed,
    input  logic             dv_ready,
    input  logic [WIDTH-1:0] dv_q,
    input  logic [WIDTH-1:0] dv_r,
    input  logic             dv_div_by_zero,
    input  logic             dv_overflow
);

`ifdef DIV_CACHE_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE,
        S_HIT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;
`endif

    state_t           state;

    // Operand register; feeds the divider directly so its inputs stay
    // stable for the whole divide.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_rem;
    logic             op_signed;

    assign dv_a         = op_a;
    assign dv_b         = op_b;
    assign dv_is_signed = op_signed;

`ifdef DIV_CACHE_EN
    logic             cache_valid;
    logic [WIDTH-1:0] cache_a;
    logic [WIDTH-1:0] cache_b;
    logic             cache_signed;
    logic [WIDTH-1:0] cache_q;
    logic [WIDTH-1:0] cache_r;
    logic             cache_dbz;
    logic             cache_ovf;
    logic             cache_hit;

    // Signedness is part of the key: DIV and DIVU of the same bits differ,
    // while DIV and REM share one divider run.
    assign cache_hit = cache_valid && (req_a == cache_a) && (req_b == cache_b)
                       && (cache_signed == ~req_op[0]);
`endif

    // Single control FSM; every interface output is registered here.
    // dv_en and resp_valid default low so each is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            dv_en      <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_dbz   <= 1'b0;
            resp_ovf   <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_rem     <= 1'b0;
            op_signed  <= 1'b0;
`ifdef DIV_CACHE_EN
            cache_valid <= 1'b0;
`endif
        end else begin
            dv_en      <= 1'b0;
            resp_valid <= 1'b0;

            unique case (state)
                // Flush is meaningless here: nothing is in flight.
                S_IDLE: begin
                    if (req_valid) begin
                        op_a      <= req_a;
                        op_b      <= req_b;
                        op_rem    <= req_op[1];
                        op_signed <= ~req_op[0];
                        req_ready <= 1'b0;
`ifdef DIV_CACHE_EN
                        if (cache_hit) begin
                            state      <= S_HIT;
                            resp_valid <= 1'b1;
                            resp_data  <= req_op[1] ? cache_r : cache_q;
                            resp_dbz   <= cache_dbz;
                            resp_ovf   <= cache_ovf;
                        end else begin
                            state <= S_ISSUE;
                            dv_en <= 1'b1;
                        end
`else
                        state <= S_ISSUE;
                        dv_en <= 1'b1;
`endif
                    end
                end

                // The start pulse is already on the wire; the divider is
                // committed, so a flush can only drain it.
                S_ISSUE: begin
                    state <= flush ? S_DRAIN : S_WAIT;
                end

                // Flush wins over a simultaneous ready: the result is
                // dropped and the divider is idle again, so go straight home.
                S_WAIT: begin
                    if (flush) begin
                        if (dv_ready) begin
                            state     <= S_IDLE;
                            req_ready <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (dv_ready) begin
                        state      <= S_DONE;
                        resp_valid <= 1'b1;
                        resp_data  <= op_rem ? dv_r : dv_q;
                        resp_dbz   <= dv_div_by_zero;
                        resp_ovf   <= dv_overflow;
`ifdef DIV_CACHE_EN
                        cache_valid  <= 1'b1;
                        cache_a      <= op_a;
                        cache_b      <= op_b;
                        cache_signed <= op_signed;
                        cache_q      <= dv_q;
                        cache_r      <= dv_r;
                        cache_dbz    <= dv_div_by_zero;
                        cache_ovf    <= dv_overflow;
`endif
                    end
                end

                // The divider cannot be aborted; hold off new requests until
                // it reports completion, then throw the result away.
                S_DRAIN: begin
                    if (dv_ready) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end

`ifdef DIV_CACHE_EN
                S_HIT: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
`endif

                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
